// File: rtl/accel_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : accel_read_scheduler
// Description : Sequences accelerometer register transfers over a
//               request/acknowledge port to a byte-level SPI engine.
//               After reset it writes a four-entry init table. It then waits
//               for a sample trigger: a timer wrap, or a rising edge of the
//               data-ready line iG_INT2. On a trigger it reads the X/Y bytes
//               and publishes them together as one sample.
// Ports       : iCLK, iRSTN (async, active-low), iEN (trigger enable)
//               iG_INT2 (async data-ready)
//               oXFER_REQ/RW/ADDR/WDATA -> transfer request
//               iXFER_ACK/RDATA <- transfer completion and read data
//               oDATA_X/oDATA_Y/oVALID   -> published sample and its strobe
//               oINIT_DONE               -> high once the init table is written
//               oERR                     -> one-cycle pulse on ACK timeout
// Revision    : 1.0 - initial release
// ============================================================================
module accel_read_scheduler #(
    parameter int SAMPLE_DIV  = 1_000_000,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic        iCLK,
    input  logic        iRSTN,
    input  logic        iEN,
    input  logic        iG_INT2,
    output logic        oXFER_REQ,
    output logic        oXFER_RW,
    output logic [5:0]  oXFER_ADDR,
    output logic [7:0]  oXFER_WDATA,
    input  logic        iXFER_ACK,
    input  logic [7:0]  iXFER_RDATA,
    output logic [15:0] oDATA_X,
    output logic [15:0] oDATA_Y,
    output logic        oVALID,
    output logic        oINIT_DONE,
    output logic        oERR
);

    localparam int TMR_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;
    localparam logic [1:0] S_PUBLISH = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       idx;
    logic             req;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMR_W-1:0] timer;
    logic             int2_meta;
    logic             int2_sync;
    logic             int2_prev;
    logic             pending;
    logic             init_done;
    logic             err;
    logic [7:0]       x_l;
    logic [7:0]       x_h;
    logic [7:0]       y_l;
    logic [15:0]      data_x;
    logic [15:0]      data_y;

    logic xfer_done;
    logic timeout;
    logic last_entry;
    logic timer_wrap;
    logic int2_edge;
    logic trigger;

    // An ACK is only meaningful while a request is outstanding.
    assign xfer_done  = req & iXFER_ACK;
    assign timeout    = req & ~iXFER_ACK & (tmo_cnt == TMO_LAST);
    assign last_entry = (idx == 2'd3);
    assign timer_wrap = iEN & init_done & (timer == TMR_LAST);
    assign int2_edge  = int2_sync & ~int2_prev;
    // OR-ing the sources merges a coincident wrap and edge into one trigger.
    assign trigger    = iEN & (int2_edge | timer_wrap);

    // ---------------------------------------------------------------- state
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: begin
                if (xfer_done && last_entry) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (trigger) state_nxt = S_READ;
            end
            S_READ: begin
                if (xfer_done && last_entry) state_nxt = S_PUBLISH;
                else if (timeout)            state_nxt = S_WAIT;
            end
            S_PUBLISH: begin
                if ((pending && iEN) || trigger) state_nxt = S_READ;
                else                             state_nxt = S_WAIT;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Address and data are decoded from state and table index. Both are
    // frozen while REQ is high, so the fields stay stable through the ACK
    // cycle. They are gated by REQ so that they read as zero in reset and
    // between transfers.
    always_comb begin
        oXFER_REQ   = req;
        oXFER_RW    = 1'b0;
        oXFER_ADDR  = 6'h00;
        oXFER_WDATA = 8'h00;
        if (req) begin
            if (state == S_INIT) begin
                case (idx)
                    2'd0:    begin oXFER_ADDR = 6'h31; oXFER_WDATA = 8'h40; end
                    2'd1:    begin oXFER_ADDR = 6'h2C; oXFER_WDATA = 8'h09; end
                    2'd2:    begin oXFER_ADDR = 6'h2E; oXFER_WDATA = 8'h10; end
                    default: begin oXFER_ADDR = 6'h2D; oXFER_WDATA = 8'h08; end
                endcase
            end else if (state == S_READ) begin
                oXFER_RW   = 1'b1;
                oXFER_ADDR = 6'h32 + {4'b0000, idx};
            end
        end
        oDATA_X    = data_x;
        oDATA_Y    = data_y;
        oVALID     = (state == S_PUBLISH);
        oINIT_DONE = init_done;
        oERR       = err;
    end

    // ---------------------------------------------- INT2 synchronizer/edge
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            int2_meta <= 1'b0;
            int2_sync <= 1'b0;
            int2_prev <= 1'b0;
        end else begin
            int2_meta <= iG_INT2;
            int2_sync <= int2_meta;
            int2_prev <= int2_sync;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            req       <= 1'b0;
            idx       <= 2'd0;
            tmo_cnt   <= '0;
            timer     <= '0;
            pending   <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
            x_l       <= 8'h00;
            x_h       <= 8'h00;
            y_l       <= 8'h00;
            data_x    <= 16'h0000;
            data_y    <= 16'h0000;
        end else begin
            err <= timeout;

            // Timer runs only while sampling is enabled after init.
            if (!(iEN && init_done) || timer_wrap) timer <= '0;
            else                                   timer <= timer + 1'b1;

            if (req && !iXFER_ACK && !timeout) tmo_cnt <= tmo_cnt + 1'b1;
            else                               tmo_cnt <= '0;

            // REQ drops after ACK or timeout. Because a new request is only
            // raised from REQ=0, at least one idle cycle separates transfers.
            if (xfer_done || timeout) begin
                req <= 1'b0;
            end else if (!req && (state == S_INIT || state == S_READ)) begin
                req <= 1'b1;
            end

            // The index wraps to 0 after the last entry, so it is already 0
            // when the next table or read sequence starts.
            if (timeout)        idx <= 2'd0;
            else if (xfer_done) idx <= idx + 2'd1;

            if (xfer_done && last_entry && state == S_INIT) init_done <= 1'b1;

            // Bytes are staged here. The visible sample changes only in one
            // assignment at the final ACK, so a partial sample is never shown.
            if (xfer_done && state == S_READ) begin
                case (idx)
                    2'd0: x_l <= iXFER_RDATA;
                    2'd1: x_h <= iXFER_RDATA;
                    2'd2: y_l <= iXFER_RDATA;
                    default: begin
                        data_x <= {x_h, x_l};
                        data_y <= {iXFER_RDATA, y_l};
                    end
                endcase
            end

            if (!iEN || timeout || state == S_PUBLISH) pending <= 1'b0;
            else if (trigger && state == S_READ)       pending <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_read_scheduler
// Description : Scoreboard bench for accel_read_scheduler. Stimulus pushes the
//               expected transfers, samples and error pulses into queues. A
//               negedge monitor pops and compares whenever the DUT raises a
//               request, publishes a sample, or pulses oERR. A responder
//               process models the SPI engine: it acknowledges each request
//               three cycles after it rises, and can withhold an ACK or inject
//               a stray one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_read_scheduler;

    localparam int SAMPLE_DIV  = 100;
    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        int2 = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  rdata = 8'hEE;
    logic        req;
    logic        rw;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] dx;
    logic [15:0] dy;
    logic        valid;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    accel_read_scheduler #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .iCLK       (clk),
        .iRSTN      (rst_n),
        .iEN        (en),
        .iG_INT2    (int2),
        .oXFER_REQ  (req),
        .oXFER_RW   (rw),
        .oXFER_ADDR (addr),
        .oXFER_WDATA(wdata),
        .iXFER_ACK  (ack),
        .iXFER_RDATA(rdata),
        .oDATA_X    (dx),
        .oDATA_Y    (dy),
        .oVALID     (valid),
        .oINIT_DONE (done),
        .oERR       (err)
    );

    // Scoreboard queues.
    logic [14:0] exp_xfer[$];   // {rw, addr, wdata}
    logic [31:0] exp_pub[$];    // {x, y}
    bit          exp_err[$];
    logic [7:0]  rd_q[$];       // read bytes the responder returns

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h expected no event", name, act);
    endfunction

    // ------------------------------------------------------------ responder
    int acks_given  = 0;
    int withhold_at = -1;
    int stray_req   = 0;
    int stray_done  = 0;
    int hi_run      = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!req) begin
                hi_run = 0;
                ack    = 1'b0;
                rdata  = 8'hEE;
                if (stray_req != stray_done) begin
                    ack   = 1'b1;
                    rdata = 8'hFF;
                    stray_done++;
                end
            end else begin
                hi_run++;
                if (hi_run == 3 && withhold_at != acks_given) begin
                    ack   = 1'b1;
                    rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    acks_given++;
                end else begin
                    ack   = 1'b0;
                    rdata = 8'hEE;
                end
            end
        end
    end

    // -------------------------------------------------------------- monitor
    int          xfer_rises = 0;
    int          pubs_seen  = 0;
    int          errs_seen  = 0;
    int          hi_cnt     = 0;
    logic        prev_req   = 1'b0;
    logic        ack_prev   = 1'b0;
    logic        ack_prev_rw = 1'b0;
    logic [14:0] cur = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req && !prev_req) begin
                    xfer_rises++;
                    hi_cnt = 0;
                    cur    = {rw, addr, wdata};
                    if (exp_xfer.size() == 0) unexpected("xfer_unexpected", cur);
                    else                      check("xfer_fields", cur, exp_xfer.pop_front());
                end
                if (req) hi_cnt++;
                if (req && ack) check("xfer_stable_at_ack", {rw, addr, wdata}, cur);
                if (ack_prev)   check("req_low_after_ack", req, 1'b0);
                if (valid) begin
                    pubs_seen++;
                    check("valid_after_4th_read_ack", ack_prev & ack_prev_rw, 1'b1);
                    if (exp_pub.size() == 0) unexpected("pub_unexpected", {dx, dy});
                    else                     check("pub_data", {dx, dy}, exp_pub.pop_front());
                end
                if (err) begin
                    errs_seen++;
                    if (exp_err.size() == 0) unexpected("err_unexpected", hi_cnt);
                    else begin
                        void'(exp_err.pop_front());
                        check("err_after_timeout_cycles", hi_cnt, ACK_TIMEOUT);
                    end
                end
                ack_prev    = req & ack;
                ack_prev_rw = rw;
                prev_req    = req;
            end else begin
                ack_prev = 1'b0;
                prev_req = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic push_init(input int n);
        logic [14:0] tbl [4];
        tbl[0] = {1'b0, 6'h31, 8'h40};
        tbl[1] = {1'b0, 6'h2C, 8'h09};
        tbl[2] = {1'b0, 6'h2E, 8'h10};
        tbl[3] = {1'b0, 6'h2D, 8'h08};
        for (int i = 0; i < n; i++) exp_xfer.push_back(tbl[i]);
    endtask

    task automatic push_sample(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < 4; i++) exp_xfer.push_back({1'b1, 6'(6'h32 + i), 8'h00});
        rd_q.push_back(b0);
        rd_q.push_back(b1);
        rd_q.push_back(b2);
        rd_q.push_back(b3);
        exp_pub.push_back({b1, b0, b3, b2});
    endtask

    task automatic pulse_int2();
        int2 = 1'b1;
        repeat (3) @(negedge clk);
        int2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_pubs(input int target, input int limit, input string name);
        for (int i = 0; i < limit && pubs_seen < target; i++) @(negedge clk);
        check(name, pubs_seen, target);
    endtask

    initial begin
        int base;

        repeat (3) @(negedge clk);
        check("reset_outputs_zero",
              {req, rw, addr, wdata, dx, dy, valid, done, err}, 51'd0);

        // Reset during the third init write abandons it; init restarts at 0x31.
        push_init(3);
        rst_n = 1'b1;
        for (int i = 0; i < 200 && xfer_rises < 3; i++) @(negedge clk);
        check("third_init_write_reached", xfer_rises, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midxfer_reset_outputs_zero",
              {req, rw, addr, wdata, dx, dy, valid, done, err}, 51'd0);
        repeat (3) @(negedge clk);
        push_init(4);
        rst_n = 1'b1;
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check("init_done", done, 1'b1);
        check("init_table_consumed", exp_xfer.size(), 0);

        // Timer-driven sample.
        push_sample(8'h11, 8'h22, 8'h33, 8'h44);
        en = 1'b1;
        wait_pubs(1, 300, "timer_sample_published");
        en = 1'b0;
        check("timer_sample_xy", {dx, dy}, {16'h2211, 16'h4433});

        // An ACK with no request outstanding must not disturb anything.
        base = xfer_rises;
        stray_req++;
        repeat (6) @(negedge clk);
        check("stray_ack_no_req", xfer_rises, base);
        check("stray_ack_data_kept", {dx, dy}, {16'h2211, 16'h4433});

        // INT2 edge and timer wrap during READ coalesce into one extra read.
        push_sample(8'h01, 8'h02, 8'h03, 8'h04);
        push_sample(8'h05, 8'h06, 8'h07, 8'h08);
        en = 1'b1;
        repeat (88) @(negedge clk);
        pulse_int2();
        repeat (2) @(negedge clk);
        pulse_int2();
        wait_pubs(3, 300, "coalesced_pubs");
        en = 1'b0;
        repeat (30) @(negedge clk);
        check("coalesced_no_extra_pub", pubs_seen, 3);

        // Withheld ACK on the second read: timeout, outputs kept, back to WAIT.
        exp_xfer.push_back({1'b1, 6'h32, 8'h00});
        exp_xfer.push_back({1'b1, 6'h33, 8'h00});
        rd_q.push_back(8'h55);
        exp_err.push_back(1'b1);
        withhold_at = acks_given + 1;
        en = 1'b1;
        pulse_int2();
        for (int i = 0; i < 200 && errs_seen < 1; i++) @(negedge clk);
        check("timeout_err_seen", errs_seen, 1);
        en = 1'b0;
        withhold_at = -1;
        repeat (5) @(negedge clk);
        check("timeout_data_kept", {dx, dy}, {16'h0605, 16'h0807});
        check("timeout_idle_req", req, 1'b0);
        push_sample(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        en = 1'b1;
        pulse_int2();
        wait_pubs(4, 200, "post_timeout_pub");
        en = 1'b0;

        // Dropping iEN mid-READ: the sample still publishes, then nothing more.
        push_sample(8'h9A, 8'hBC, 8'hDE, 8'hF0);
        base = acks_given;
        en = 1'b1;
        pulse_int2();
        for (int i = 0; i < 100 && acks_given < base + 1; i++) @(negedge clk);
        check("en_drop_first_ack", acks_given, base + 1);
        en = 1'b0;
        wait_pubs(5, 200, "en_drop_pub");
        base = xfer_rises;
        pulse_int2();
        pulse_int2();
        repeat (250) @(negedge clk);
        check("en_drop_no_req", xfer_rises, base);
        check("en_drop_xy", {dx, dy}, {16'hBC9A, 16'hF0DE});

        check("xfer_queue_empty", exp_xfer.size(), 0);
        check("pub_queue_empty", exp_pub.size(), 0);
        check("err_queue_empty", exp_err.size(), 0);
        check("rdata_queue_empty", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
